// File: rtl/haz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : haz_pkg                                                       |
// | Purpose    : Shared types and helpers for the hazard / forwarding          |
// |              controller: operand-mux select encodings, the pipeline slot   |
// |              record and the "slot writes register r" predicate.            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package haz_pkg;

  // ALU operand mux select encodings.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // The slot record is sized for the largest supported configuration.
  // Narrower register indices are zero-extended into it, and unused source
  // lanes stay at zero, so one type serves every parameterisation.
  localparam int HAZ_AW_MAX  = 8;
  localparam int HAZ_SRC_MAX = 4;

  typedef struct packed {
    logic                                   vld;
    logic [HAZ_AW_MAX-1:0]                  rd;
    logic                                   wr_en;
    logic                                   is_load;
    logic                                   is_store;
    logic [HAZ_SRC_MAX-1:0][HAZ_AW_MAX-1:0] src;
    logic [HAZ_SRC_MAX-1:0]                 src_used;
  } haz_slot_t;

  // True when the slot holds a live instruction that will write register idx.
  // With a hardwired zero register, writes to r0 are never visible.
  function automatic logic slot_writes(input haz_slot_t             slot,
                                       input logic [HAZ_AW_MAX-1:0] idx,
                                       input logic                  zero_hw);
    return slot.vld & slot.wr_en & (slot.rd == idx) & ~(zero_hw & (idx == '0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/haz_pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : haz_pipe_slot                                                 |
// | Purpose    : One pipeline metadata slot (EX, MEM or WB). Holds its value   |
// |              while the pipeline is frozen, can load a bubble instead of    |
// |              the upstream slot, and clears asynchronously on reset.        |
// | Ports      : clk      - clock                                              |
// |              rst_n    - asynchronous active-low reset                      |
// |              hold     - freeze the slot (takes precedence over bubble)     |
// |              bubble   - load an empty slot instead of slot_in              |
// |              slot_in  - upstream slot contents                             |
// |              slot_out - registered slot contents                           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module haz_pipe_slot
  import haz_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      bubble,
  input  haz_slot_t slot_in,
  output haz_slot_t slot_out
);

  haz_slot_t slot_d;
  haz_slot_t slot_q;

  // A bubble is a fully zeroed slot, not just vld=0, so stale source and
  // store flags can never leak into downstream decode.
  always_comb begin
    slot_d = slot_q;
    if (!hold) begin
      if (bubble) begin
        slot_d = '0;
      end else begin
        slot_d = slot_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_out = slot_q;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hazard_fwd_ctrl                                               |
// | Purpose    : Hazard detection and operand forwarding control for the       |
// |              16-bit pipelined CPU. Tracks destination metadata of the      |
// |              instructions in EX, MEM and WB, drives the per-operand ALU    |
// |              mux selects, inserts one bubble per load-use pair, honours    |
// |              branch flush and freezes on an external memory stall.         |
// | Ports      : clk, rst_n      - clock, asynchronous active-low reset        |
// |              id_vld          - valid instruction in ID                     |
// |              id_src          - packed source indices (src i at i*REG_AW)   |
// |              id_src_used     - per-source read enables                     |
// |              id_rd, id_wr_en - destination index and write enable          |
// |              id_is_load      - ID instruction is a load                    |
// |              id_is_store     - ID instruction is a store (src 1 = data)    |
// |              flush           - branch taken, kill the ID instruction       |
// |              stall_ext       - memory busy, freeze the whole pipeline      |
// |              fwd_sel         - 2-bit select per source for EX operands     |
// |              stall           - hold PC and IF/ID, bubble into EX           |
// |              id_wb_byp       - ID source matches the WB-slot write         |
// |              mem_store_fwd   - store data in MEM taken from MEM/WB         |
// | Options    : HAZ_MEM2MEM_FWD_EN - a store whose data operand depends on    |
// |              the load directly ahead does not stall; the data is picked    |
// |              up from MEM/WB while the store is in MEM.                     |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module hazard_fwd_ctrl
  import haz_pkg::*;
#(
  parameter int REG_AW             = 4,
  parameter int NUM_SRC            = 2,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int WB_BYPASS          = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_vld,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      id_is_store,
  input  logic                      flush,
  input  logic                      stall_ext,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        id_wb_byp,
  output logic                      mem_store_fwd
);

  localparam logic ZERO_HW    = (ZERO_REG_HARDWIRED != 0);
  localparam logic WB_FLAG_EN = (WB_BYPASS == 0);

  haz_slot_t            id_slot;
  haz_slot_t            ex_slot;
  haz_slot_t            mem_slot;
  haz_slot_t            wb_slot;
  logic [NUM_SRC-1:0]   load_use;
  logic [NUM_SRC-1:0]   load_use_eff;
  logic                 ex_bubble;

  // Repack the ID-stage fields into the common slot record.
  always_comb begin
    id_slot          = '0;
    id_slot.vld      = id_vld;
    id_slot.rd       = HAZ_AW_MAX'(id_rd);
    id_slot.wr_en    = id_wr_en;
    id_slot.is_load  = id_is_load;
    id_slot.is_store = id_is_store;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_slot.src[i]      = HAZ_AW_MAX'(id_src[i*REG_AW +: REG_AW]);
      id_slot.src_used[i] = id_src_used[i];
    end
  end

  // Flush and load-use stall both turn the EX entry into a bubble; the ID
  // instruction is either killed (flush) or re-presented next cycle (stall).
  assign ex_bubble = flush | stall;

  haz_pipe_slot u_ex_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall_ext),
    .bubble   (ex_bubble),
    .slot_in  (id_slot),
    .slot_out (ex_slot)
  );

  haz_pipe_slot u_mem_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall_ext),
    .bubble   (1'b0),
    .slot_in  (ex_slot),
    .slot_out (mem_slot)
  );

  haz_pipe_slot u_wb_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall_ext),
    .bubble   (1'b0),
    .slot_in  (mem_slot),
    .slot_out (wb_slot)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic ex_rd_src;
    logic mem_hit;
    logic wb_hit;

    assign ex_rd_src = ex_slot.vld & ex_slot.src_used[i];

    // A load sitting in MEM has no result yet; the load-use stall makes
    // sure the consumer only reaches EX once the load is in WB.
    assign mem_hit = ex_rd_src & ~mem_slot.is_load
                   & slot_writes(mem_slot, ex_slot.src[i], ZERO_HW);
    assign wb_hit  = ex_rd_src & slot_writes(wb_slot, ex_slot.src[i], ZERO_HW);

    // MEM holds the younger producer, so it wins over WB.
    assign fwd_sel[2*i +: 2] = mem_hit ? FWD_EXMEM :
                               wb_hit  ? FWD_MEMWB : FWD_REG;

    assign load_use[i] = id_src_used[i] & ex_slot.is_load
                       & slot_writes(ex_slot, id_slot.src[i], ZERO_HW);

    assign id_wb_byp[i] = WB_FLAG_EN & id_vld & id_src_used[i]
                        & slot_writes(wb_slot, id_slot.src[i], ZERO_HW);
  end

`ifdef HAZ_MEM2MEM_FWD_EN
  if (NUM_SRC > 1) begin : g_m2m
    // Store data is only needed in MEM, by which time the load is in WB,
    // so a dependence on the store-data operand alone needs no bubble.
    always_comb begin
      load_use_eff = load_use;
      if (id_is_store) begin
        load_use_eff[1] = 1'b0;
      end
    end

    assign mem_store_fwd = mem_slot.vld & mem_slot.is_store & mem_slot.src_used[1]
                         & wb_slot.is_load
                         & slot_writes(wb_slot, mem_slot.src[1], ZERO_HW);
  end else begin : g_m2m_none
    assign load_use_eff  = load_use;
    assign mem_store_fwd = 1'b0;
  end
`else
  assign load_use_eff  = load_use;
  assign mem_store_fwd = 1'b0;
`endif

  // A flushed instruction is discarded, so its dependences are irrelevant.
  // stall_ext is deliberately not folded in: the freeze already holds EX.
  assign stall = id_vld & ~flush & (|load_use_eff);

  // Not every slot field feeds decode in every stage / build.
  logic unused_bits;
  assign unused_bits = ^{ex_slot, mem_slot, wb_slot, id_is_store};

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_hazard_fwd_ctrl                                            |
// | Purpose    : Directed self-checking bench for hazard_fwd_ctrl (default     |
// |              parameters). Each cycle drives an ID instruction, queues the  |
// |              expected outputs and compares them mid-cycle. Expectations    |
// |              for the load->store pair follow HAZ_MEM2MEM_FWD_EN.           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_vld;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] id_rd;
  logic       id_wr_en;
  logic       id_is_load;
  logic       id_is_store;
  logic       flush;
  logic       stall_ext;
  logic [3:0] fwd_sel;
  logic       stall;
  logic [1:0] id_wb_byp;
  logic       mem_store_fwd;

  hazard_fwd_ctrl #(
    .REG_AW             (4),
    .NUM_SRC            (2),
    .ZERO_REG_HARDWIRED (1),
    .WB_BYPASS          (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_vld        (id_vld),
    .id_src        (id_src),
    .id_src_used   (id_src_used),
    .id_rd         (id_rd),
    .id_wr_en      (id_wr_en),
    .id_is_load    (id_is_load),
    .id_is_store   (id_is_store),
    .flush         (flush),
    .stall_ext     (stall_ext),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .id_wb_byp     (id_wb_byp),
    .mem_store_fwd (mem_store_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [1:0] used;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
    logic       st;
  } ins_t;

  typedef struct {
    string      tag;
    logic [3:0] fwd;
    logic       stl;
    logic [1:0] byp;
    logic       msf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic ins_t nop();
    ins_t x;
    x = '0;
    return x;
  endfunction

  function automatic ins_t alu(input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b);
    ins_t x;
    x = '0;
    x.vld = 1'b1; x.s0 = a; x.s1 = b; x.used = 2'b11; x.rd = rd; x.wr = 1'b1;
    return x;
  endfunction

  function automatic ins_t lw(input logic [3:0] rd, input logic [3:0] a);
    ins_t x;
    x = '0;
    x.vld = 1'b1; x.s0 = a; x.used = 2'b01; x.rd = rd; x.wr = 1'b1; x.ld = 1'b1;
    return x;
  endfunction

  function automatic ins_t sw(input logic [3:0] addr, input logic [3:0] data);
    ins_t x;
    x = '0;
    x.vld = 1'b1; x.s0 = addr; x.s1 = data; x.used = 2'b11; x.st = 1'b1;
    return x;
  endfunction

  function automatic ins_t rdr(input logic [3:0] a, input logic [3:0] b, input logic [1:0] used);
    ins_t x;
    x = '0;
    x.vld = 1'b1; x.s0 = a; x.s1 = b; x.used = used;
    return x;
  endfunction

  task automatic apply(input ins_t ins, input logic fl, input logic se);
    id_vld      = ins.vld;
    id_src      = {ins.s1, ins.s0};
    id_src_used = ins.used;
    id_rd       = ins.rd;
    id_wr_en    = ins.wr;
    id_is_load  = ins.ld;
    id_is_store = ins.st;
    flush       = fl;
    stall_ext   = se;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] f, input logic s,
                          input logic [1:0] b, input logic m);
    exp_t e;
    e.tag = tag; e.fwd = f; e.stl = s; e.byp = b; e.msf = m;
    exp_q.push_back(e);
  endtask

  // Called 1 time unit after a rising edge; compares on the falling edge.
  task automatic check_now();
    exp_t e;
    #4;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got %0d entries, required at least 1", exp_q.size());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (fwd_sel === e.fwd) else begin
        errors++;
        $error("FAIL %s fwd_sel: got %b required %b", e.tag, fwd_sel, e.fwd);
      end
      checks++;
      assert (stall === e.stl) else begin
        errors++;
        $error("FAIL %s stall: got %b required %b", e.tag, stall, e.stl);
      end
      checks++;
      assert (id_wb_byp === e.byp) else begin
        errors++;
        $error("FAIL %s id_wb_byp: got %b required %b", e.tag, id_wb_byp, e.byp);
      end
      checks++;
      assert (mem_store_fwd === e.msf) else begin
        errors++;
        $error("FAIL %s mem_store_fwd: got %b required %b", e.tag, mem_store_fwd, e.msf);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input ins_t ins, input logic fl, input logic se,
                     input logic [3:0] f, input logic s, input logic [1:0] b, input logic m);
    apply(ins, fl, se);
    push_exp(tag, f, s, b, m);
    check_now();
    step();
  endtask

  task automatic go(input string tag, input ins_t ins,
                    input logic [3:0] f, input logic s, input logic [1:0] b);
    cyc(tag, ins, 1'b0, 1'b0, f, s, b, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    apply(nop(), 1'b0, 1'b0);
    step();
    go("reset", nop(), 4'b0000, 1'b0, 2'b00);
    rst_n = 1'b1;

    // ALU producer -> consumers one and two cycles later.
    go("t1_add_r3",   alu(4'd3, 4'd1, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t1_add_r4",   alu(4'd4, 4'd3, 4'd5),  4'b0000, 1'b0, 2'b00);
    go("t1_exmem",    alu(4'd6, 4'd3, 4'd7),  4'b0001, 1'b0, 2'b00);
    go("t1_memwb",    rdr(4'd0, 4'd3, 2'b10), 4'b0010, 1'b0, 2'b10);
    go("t1_drain",    nop(),                  4'b0000, 1'b0, 2'b00);

    // Two producers of r8 in MEM and WB: the younger (MEM) wins.
    go("t1b_p1",      alu(4'd8, 4'd1, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t1b_p2",      alu(4'd8, 4'd1, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t1b_rd",      rdr(4'd8, 4'd8, 2'b11), 4'b0000, 1'b0, 2'b00);
    go("t1b_prio",    nop(),                  4'b0101, 1'b0, 2'b00);
    go("t1b_drain",   nop(),                  4'b0000, 1'b0, 2'b00);

    // Load-use: one stall cycle, ADD re-presented, then MEM/WB forward.
    go("t2_lw",       lw(4'd5, 4'd1),         4'b0000, 1'b0, 2'b00);
    go("t2_stall",    alu(4'd6, 4'd5, 4'd2),  4'b0000, 1'b1, 2'b00);
    go("t2_bubble",   alu(4'd6, 4'd5, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t2_fwd_wb",   rdr(4'd5, 4'd0, 2'b01), 4'b0010, 1'b0, 2'b01);
    go("t2_drain",    nop(),                  4'b0000, 1'b0, 2'b00);

    // Register 0 never forwards, stalls or flags a WB match.
    go("t3_w_r0",     alu(4'd0, 4'd1, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t3_lw_r0",    lw(4'd0, 4'd1),         4'b0000, 1'b0, 2'b00);
    go("t3_rd_r0",    rdr(4'd0, 4'd0, 2'b11), 4'b0000, 1'b0, 2'b00);
    go("t3_ex_r0",    nop(),                  4'b0000, 1'b0, 2'b00);
    go("t3_byp_r0",   rdr(4'd0, 4'd0, 2'b11), 4'b0000, 1'b0, 2'b00);
    go("t3_drain",    nop(),                  4'b0000, 1'b0, 2'b00);

    // External stall freezes the EX/MEM forward for several cycles.
    go("t4_add_r4",   alu(4'd4, 4'd1, 4'd2),  4'b0000, 1'b0, 2'b00);
    go("t4_rd_r4",    alu(4'd9, 4'd4, 4'd3),  4'b0000, 1'b0, 2'b00);
    cyc("t4_hold1",   nop(), 1'b0, 1'b1, 4'b0001, 1'b0, 2'b00, 1'b0);
    cyc("t4_hold2",   nop(), 1'b0, 1'b1, 4'b0001, 1'b0, 2'b00, 1'b0);
    cyc("t4_hold3",   nop(), 1'b0, 1'b1, 4'b0001, 1'b0, 2'b00, 1'b0);
    go("t4_release",  nop(),                  4'b0001, 1'b0, 2'b00);
    go("t4_shifted",  nop(),                  4'b0000, 1'b0, 2'b00);

    // Flush on top of a load-use hazard: no stall, killed op never forwards.
    go("t5_lw",       lw(4'd10, 4'd1),        4'b0000, 1'b0, 2'b00);
    cyc("t5_flush",   alu(4'd11, 4'd10, 4'd2), 1'b1, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
    go("t5_bubble",   rdr(4'd11, 4'd10, 2'b11), 4'b0000, 1'b0, 2'b00);
    go("t5_no_kill",  nop(),                  4'b1000, 1'b0, 2'b00);
    go("t5_drain",    nop(),                  4'b0000, 1'b0, 2'b00);

    // Load followed by a store of the loaded value.
    go("t6_lw",       lw(4'd7, 4'd2),         4'b0000, 1'b0, 2'b00);
`ifdef HAZ_MEM2MEM_FWD_EN
    go("t6_sw",       sw(4'd1, 4'd7),         4'b0000, 1'b0, 2'b00);
    go("t6_sw_ex",    nop(),                  4'b0000, 1'b0, 2'b00);
    cyc("t6_sw_mem",  nop(), 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    go("t6_drain",    nop(),                  4'b0000, 1'b0, 2'b00);
`else
    go("t6_sw_stall", sw(4'd1, 4'd7),         4'b0000, 1'b1, 2'b00);
    go("t6_bubble",   sw(4'd1, 4'd7),         4'b0000, 1'b0, 2'b00);
    go("t6_sw_ex",    nop(),                  4'b1000, 1'b0, 2'b00);
    go("t6_sw_mem",   nop(),                  4'b0000, 1'b0, 2'b00);
`endif
    // Store whose address depends on the load always stalls.
    go("t6b_lw",      lw(4'd7, 4'd2),         4'b0000, 1'b0, 2'b00);
    go("t6b_stall",   sw(4'd7, 4'd1),         4'b0000, 1'b1, 2'b00);
    go("t6b_bubble",  sw(4'd7, 4'd1),         4'b0000, 1'b0, 2'b00);
    go("t6b_fwd",     nop(),                  4'b0010, 1'b0, 2'b00);
    go("t6b_drain",   nop(),                  4'b0000, 1'b0, 2'b00);

    // Reset mid-stream discards the in-flight producer of r12.
    go("t7_add_r12",  alu(4'd12, 4'd1, 4'd2), 4'b0000, 1'b0, 2'b00);
    apply(rdr(4'd12, 4'd12, 2'b11), 1'b0, 1'b0);
    rst_n = 1'b0;
    push_exp("t7_in_reset", 4'b0000, 1'b0, 2'b00, 1'b0);
    check_now();
    step();
    rst_n = 1'b1;
    go("t7_after",    rdr(4'd12, 4'd12, 2'b11), 4'b0000, 1'b0, 2'b00);
    go("t7_after2",   nop(),                  4'b0000, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
